vga_timing_gen: RTL and testbench

Generates the 640x480 at 60 Hz VGA raster timing that drives the pong video path. It owns the horizontal and vertical pixel counters and exports them as DrawX/DrawY. It also produces the blank qualifier consumed by the colour mapping and sprite logic, and the hs/vs sync strobes sent to the DAC connector. vs also serves as the game's frame_clk.

---
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing for the pong video path.
// Pixel divider, h/v counters and registered sync/blank decode.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       pixel_clk,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] PC_FALL  = DW'(CLK_DIV / 2 - 1);

  logic [DW-1:0] div_cnt;
  logic [9:0]    hcount;
  logic [9:0]    vcount;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic          step;
  logic          h_wrap;
  logic          f_wrap;

  // Next raster position; outputs decode from it so they match the counters
  always_comb begin
    step   = (div_cnt == DIV_LAST);
    h_wrap = step && (hcount == H_LAST);
    f_wrap = h_wrap && (vcount == V_LAST);
    h_nxt  = hcount;
    v_nxt  = vcount;
    if (step)
      h_nxt = h_wrap ? 10'd0 : hcount + 10'd1;
    if (h_wrap)
      v_nxt = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
  end

  // Clock divider and 50% duty pixel clock rising on each pixel step
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt   <= '0;
      pixel_clk <= 1'b0;
    end else if (step) begin
      div_cnt   <= '0;
      pixel_clk <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
      if (div_cnt == PC_FALL)
        pixel_clk <= 1'b0;
    end
  end

  // Raster counters with registered sync, blank and frame pulse
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hs          <= !((h_nxt >= HS_ON) && (h_nxt < HS_OFF));
      vs          <= !((v_nxt >= VS_ON) && (v_nxt < VS_OFF));
      blank       <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      frame_start <= f_wrap;
    end
  end

  assign DrawX = hcount;
  assign DrawY = vcount;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed table plus corner sequences.
// Uses default, shrunken-raster and CLK_DIV=4 instances.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  logic rst2 = 1'b0;

  logic pc0, hs0, vs0, bl0, fs0;
  logic [9:0] x0, y0;
  logic pc1, hs1, vs1, bl1, fs1;
  logic [9:0] x1, y1;
  logic pc2, hs2, vs2, bl2, fs2;
  logic [9:0] x2, y2;

  always #5 clk = ~clk;

  vga_timing_gen d0 (
    .Clk(clk), .Reset_n(rst0), .pixel_clk(pc0),
    .hs(hs0), .vs(vs0), .blank(bl0),
    .DrawX(x0), .DrawY(y0), .frame_start(fs0)
  );

  // 15 x 11 raster: hs low x=10..12, vs low y=7..8, visible 8x6
  vga_timing_gen #(
    .CLK_DIV(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) d1 (
    .Clk(clk), .Reset_n(rst1), .pixel_clk(pc1),
    .hs(hs1), .vs(vs1), .blank(bl1),
    .DrawX(x1), .DrawY(y1), .frame_start(fs1)
  );

  vga_timing_gen #(.CLK_DIV(4)) d2 (
    .Clk(clk), .Reset_n(rst2), .pixel_clk(pc2),
    .hs(hs2), .vs(vs2), .blank(bl2),
    .DrawX(x2), .DrawY(y2), .frame_start(fs2)
  );

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int cyc;
    int x;
    int y;
    int hs;
    int vs;
    int blank;
    int pclk;
    int fs;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl[NV];

  int e, p, ex, ey, lo0, bz0, vlo, lo2;
  int fs_edges[$];

  initial begin
    tbl[0]  = '{1,     0,   0,  1, 1, 1, 0, 0};
    tbl[1]  = '{2,     1,   0,  1, 1, 1, 1, 0};
    tbl[2]  = '{3,     1,   0,  1, 1, 1, 0, 0};
    tbl[3]  = '{4,     2,   0,  1, 1, 1, 1, 0};
    tbl[4]  = '{5,     2,   0,  1, 1, 1, 0, 0};
    tbl[5]  = '{1278,  639, 0,  1, 1, 1, 1, 0};
    tbl[6]  = '{1280,  640, 0,  1, 1, 0, 1, 0};
    tbl[7]  = '{1310,  655, 0,  1, 1, 0, 1, 0};
    tbl[8]  = '{1312,  656, 0,  0, 1, 0, 1, 0};
    tbl[9]  = '{1502,  751, 0,  0, 1, 0, 1, 0};
    tbl[10] = '{1504,  752, 0,  1, 1, 0, 1, 0};
    tbl[11] = '{1598,  799, 0,  1, 1, 0, 1, 0};
    tbl[12] = '{1600,  0,   1,  1, 1, 1, 1, 0};
    tbl[13] = '{17598, 799, 10, 1, 1, 0, 1, 0};
    tbl[14] = '{17600, 0,   11, 1, 1, 1, 1, 0};
    tbl[15] = '{17601, 0,   11, 1, 1, 1, 0, 0};

    // Reset state of the default instance
    repeat (5) @(posedge clk);
    #1;
    chk("rst_x", x0, 0);
    chk("rst_y", y0, 0);
    chk("rst_hs", hs0, 1);
    chk("rst_vs", vs0, 1);
    chk("rst_blank", bl0, 1);
    chk("rst_pclk", pc0, 0);
    chk("rst_fs", fs0, 0);

    // Table run on the default raster
    @(negedge clk);
    rst0 = 1'b1;
    e = 0;
    lo0 = 0;
    bz0 = 0;
    for (int i = 0; i < NV; i++) begin
      while (e < tbl[i].cyc) begin
        @(posedge clk);
        #1;
        e++;
        if (e <= 1600 && !hs0) lo0++;
        if (e <= 1600 && !bl0) bz0++;
      end
      chk($sformatf("v%0d_x", i), x0, tbl[i].x);
      chk($sformatf("v%0d_y", i), y0, tbl[i].y);
      chk($sformatf("v%0d_hs", i), hs0, tbl[i].hs);
      chk($sformatf("v%0d_vs", i), vs0, tbl[i].vs);
      chk($sformatf("v%0d_blank", i), bl0, tbl[i].blank);
      chk($sformatf("v%0d_pclk", i), pc0, tbl[i].pclk);
      chk($sformatf("v%0d_fs", i), fs0, tbl[i].fs);
    end
    chk("hs_low_cycles", lo0, 192);
    chk("blank_low_cycles", bz0, 320);

    // Held-reset instance stays static
    chk("held_x", x2, 0);
    chk("held_hs", hs2, 1);
    chk("held_pclk", pc2, 0);
    chk("held_blank", bl2, 1);

    // Small raster: two full frames checked every edge
    @(negedge clk);
    rst1 = 1'b1;
    vlo = 0;
    for (int n = 1; n <= 922; n++) begin
      @(posedge clk);
      #1;
      p  = n / 2;
      ex = p % 15;
      ey = (p / 15) % 11;
      chk($sformatf("s_x@%0d", n), x1, ex);
      chk($sformatf("s_y@%0d", n), y1, ey);
      chk($sformatf("s_hs@%0d", n), hs1,
          int'(!(ex >= 10 && ex < 13)));
      chk($sformatf("s_vs@%0d", n), vs1,
          int'(!(ey >= 7 && ey < 9)));
      chk($sformatf("s_blank@%0d", n), bl1,
          int'(ex < 8 && ey < 6));
      chk($sformatf("s_pclk@%0d", n), pc1,
          int'(n >= 2 && n % 2 == 0));
      chk($sformatf("s_fs@%0d", n), fs1,
          int'(n % 2 == 0 && p % 165 == 0));
      if (fs1) fs_edges.push_back(n);
      if (n > 330 && n <= 660 && !vs1) vlo++;
    end
    chk("fs_count", fs_edges.size(), 2);
    if (fs_edges.size() >= 2)
      chk("fs_period", fs_edges[1] - fs_edges[0], 330);
    chk("vs_low_cycles", vlo, 60);

    // Async reset at (11,8) with hs and vs low
    chk("pre_rst_hs", hs1, 0);
    chk("pre_rst_vs", vs1, 0);
    #2;
    rst1 = 1'b0;
    #1;
    chk("mid_rst_x", x1, 0);
    chk("mid_rst_y", y1, 0);
    chk("mid_rst_hs", hs1, 1);
    chk("mid_rst_vs", vs1, 1);
    chk("mid_rst_blank", bl1, 1);
    chk("mid_rst_pclk", pc1, 0);
    chk("mid_rst_fs", fs1, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("held_fs", fs1, 0);
      chk("held_x1", x1, 0);
    end
    @(negedge clk);
    rst1 = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("restart_x@%0d", n), x1, n / 2);
      chk($sformatf("restart_y@%0d", n), y1, 0);
      chk($sformatf("restart_fs@%0d", n), fs1, 0);
    end

    // CLK_DIV = 4 variant
    @(negedge clk);
    rst2 = 1'b1;
    lo2 = 0;
    for (int n = 1; n <= 3300; n++) begin
      @(posedge clk);
      #1;
      if (n <= 16) begin
        chk($sformatf("d4_pclk@%0d", n), pc2,
            int'(n >= 4 && n % 4 < 2));
        chk($sformatf("d4_x@%0d", n), x2, n / 4);
      end
      if (n <= 3200 && !hs2) lo2++;
    end
    chk("d4_hs_low_cycles", lo2, 384);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
